frame_writer: RTL and testbench



---
 rtl/gpu_pkg.sv | 26 ++
 rtl/sync_2ff.sv | 22 ++
 rtl/frame_writer.sv | 133 +++++++++++++
 tb/tb_frame_writer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared frame store geometry, types and address helper
package gpu_pkg;

  localparam int H_RES     = 320;
  localparam int V_RES     = 240;
  localparam int FB_WORDS  = 76800;
  localparam int FB_ADDR_W = 17;

  typedef logic [2:0]           color_t;
  typedef logic [FB_ADDR_W-1:0] fb_addr_t;

  typedef enum logic [1:0] {
    CLEAR,
    DRAW,
    ARM,
    DONE
  } fw_state_t;

  // y*320 + x using shifts and adds only: 320 = 256 + 64
  function automatic fb_addr_t pixel_addr(input logic [8:0] x, input logic [7:0] y);
    fb_addr_t yy;
    yy = {9'd0, y};
    return (yy << 8) + (yy << 6) + {8'd0, x};
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop single-bit synchronizer
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // two back-to-back flops resolve metastability on the asynchronous input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/frame_writer.sv
// rtl/frame_writer.sv - back-buffer clear/draw controller with swap handshake
module frame_writer
  import gpu_pkg::*;
#(
  parameter bit     CLEAR_EN = 1'b1,
  parameter color_t BG_COLOR = 3'b000
) (
  input  logic                 CLOCK_50,
  input  logic                 RESET_N,
  input  logic                 px_valid,
  output logic                 px_ready,
  input  logic [8:0]           px_x,
  input  logic [7:0]           px_y,
  input  color_t               px_color,
  input  logic                 px_last,
  input  logic                 frame_switched,
  output logic                 DRAW_DONE,
  output logic                 BUFFER1_WR,
  output logic                 BUFFER2_WR,
  output logic                 BUFFER1_WR_CLK,
  output logic                 BUFFER2_WR_CLK,
  output color_t               BUFFER1_DATA,
  output color_t               BUFFER2_DATA,
  output logic [FB_ADDR_W-1:0] BUFFER1_ADDR,
  output logic [FB_ADDR_W-1:0] BUFFER2_ADDR
);

  fw_state_t state, state_nxt;
  logic      back_buf;
  fb_addr_t  clr_addr;
  logic      fs_s;
  logic      in_range;
  logic      clr_last;

  logic      issue_en;
  fb_addr_t  issue_addr;
  color_t    issue_data;

  logic      wr_en;
  logic      wr_sel;
  fb_addr_t  wr_addr;
  color_t    wr_data;

  sync_2ff u_fs_sync (
    .clk   (CLOCK_50),
    .rst_n (RESET_N),
    .d     (frame_switched),
    .q     (fs_s)
  );

  assign in_range = (px_x < 9'(H_RES)) && (px_y < 8'(V_RES));
  assign clr_last = (clr_addr == fb_addr_t'(FB_WORDS - 1));

  // next state, handshake outputs and the write request for this cycle
  always_comb begin
    state_nxt  = state;
    px_ready   = 1'b0;
    DRAW_DONE  = 1'b0;
    issue_en   = 1'b0;
    issue_addr = '0;
    issue_data = '0;
    case (state)
      CLEAR: begin
        if (!CLEAR_EN) begin
          state_nxt = DRAW;
        end else begin
          issue_en   = 1'b1;
          issue_addr = clr_addr;
          issue_data = BG_COLOR;
          if (clr_last) state_nxt = DRAW;
        end
      end
      DRAW: begin
        px_ready = 1'b1;
        if (px_valid) begin
          if (in_range) begin
            issue_en   = 1'b1;
            issue_addr = pixel_addr(px_x, px_y);
            issue_data = px_color;
          end
          if (px_last) state_nxt = ARM;
        end
      end
      // a still-high acknowledge from the previous swap must drain first
      ARM: begin
        if (!fs_s) state_nxt = DONE;
      end
      DONE: begin
        DRAW_DONE = 1'b1;
        if (fs_s) state_nxt = CLEAR;
      end
      default: state_nxt = CLEAR;
    endcase
  end

  // state, buffer ownership and clear counter
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= CLEAR;
      back_buf <= 1'b1;
      clr_addr <= '0;
    end else begin
      state <= state_nxt;
      if (state == DONE && fs_s) back_buf <= ~back_buf;
      if (state == CLEAR && CLEAR_EN) clr_addr <= clr_last ? '0 : clr_addr + 1'b1;
    end
  end

  // single registered write stage; buffer choice is frozen at issue time
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_en   <= 1'b0;
      wr_sel  <= 1'b1;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en   <= issue_en;
      wr_addr <= issue_addr;
      wr_data <= issue_data;
      if (issue_en) wr_sel <= back_buf;
    end
  end

  assign BUFFER1_WR     = wr_en & ~wr_sel;
  assign BUFFER2_WR     = wr_en & wr_sel;
  assign BUFFER1_DATA   = wr_sel ? '0 : wr_data;
  assign BUFFER2_DATA   = wr_sel ? wr_data : '0;
  assign BUFFER1_ADDR   = wr_sel ? '0 : wr_addr;
  assign BUFFER2_ADDR   = wr_sel ? wr_addr : '0;
  assign BUFFER1_WR_CLK = CLOCK_50;
  assign BUFFER2_WR_CLK = CLOCK_50;

endmodule

// File: tb/tb_frame_writer.sv
// tb/tb_frame_writer.sv - scoreboard bench for frame_writer
module tb_frame_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b;
  logic       px_valid, px_last, frame_switched;
  logic [8:0] px_x;
  logic [7:0] px_y;
  logic [2:0] px_color;

  logic        a_ready, a_dd, a_wr1, a_wr2, a_clk1, a_clk2;
  logic [2:0]  a_d1, a_d2;
  logic [16:0] a_a1, a_a2;
  logic        b_ready, b_dd, b_wr1, b_wr2, b_clk1, b_clk2;
  logic [2:0]  b_d1, b_d2;
  logic [16:0] b_a1, b_a2;

  frame_writer #(.CLEAR_EN(1'b1), .BG_COLOR(3'b010)) u_a (
    .CLOCK_50(clk), .RESET_N(rst_a), .px_valid(px_valid), .px_ready(a_ready),
    .px_x(px_x), .px_y(px_y), .px_color(px_color), .px_last(px_last),
    .frame_switched(frame_switched), .DRAW_DONE(a_dd),
    .BUFFER1_WR(a_wr1), .BUFFER2_WR(a_wr2), .BUFFER1_WR_CLK(a_clk1), .BUFFER2_WR_CLK(a_clk2),
    .BUFFER1_DATA(a_d1), .BUFFER2_DATA(a_d2), .BUFFER1_ADDR(a_a1), .BUFFER2_ADDR(a_a2)
  );

  frame_writer #(.CLEAR_EN(1'b0), .BG_COLOR(3'b000)) u_b (
    .CLOCK_50(clk), .RESET_N(rst_b), .px_valid(px_valid), .px_ready(b_ready),
    .px_x(px_x), .px_y(px_y), .px_color(px_color), .px_last(px_last),
    .frame_switched(frame_switched), .DRAW_DONE(b_dd),
    .BUFFER1_WR(b_wr1), .BUFFER2_WR(b_wr2), .BUFFER1_WR_CLK(b_clk1), .BUFFER2_WR_CLK(b_clk2),
    .BUFFER1_DATA(b_d1), .BUFFER2_DATA(b_d2), .BUFFER1_ADDR(b_a1), .BUFFER2_ADDR(b_a2)
  );

  bit          sel_b;
  logic        m_ready, m_dd, m_wr1, m_wr2, m_clk1, m_clk2;
  logic [2:0]  m_d1, m_d2;
  logic [16:0] m_a1, m_a2;
  assign m_ready = sel_b ? b_ready : a_ready;
  assign m_dd    = sel_b ? b_dd    : a_dd;
  assign m_wr1   = sel_b ? b_wr1   : a_wr1;
  assign m_wr2   = sel_b ? b_wr2   : a_wr2;
  assign m_clk1  = sel_b ? b_clk1  : a_clk1;
  assign m_clk2  = sel_b ? b_clk2  : a_clk2;
  assign m_d1    = sel_b ? b_d1    : a_d1;
  assign m_d2    = sel_b ? b_d2    : a_d2;
  assign m_a1    = sel_b ? b_a1    : a_a1;
  assign m_a2    = sel_b ? b_a2    : a_a2;

  typedef struct {
    bit to_b2;
    int addr;
    int data;
    int due;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  bit  model_b2;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic push_wr(input bit to_b2, input int addr, input int data, input int due);
    wr_t w;
    w.to_b2 = to_b2;
    w.addr  = addr;
    w.data  = data;
    w.due   = due;
    exp_q.push_back(w);
  endtask

  // monitor: pops the scoreboard whenever either buffer write port fires
  always @(negedge clk) begin
    wr_t e;
    chk("wr_clk_follows_clock", {m_clk1, m_clk2}, 2'b00);
    if (m_wr1 || m_wr2) begin
      chk("single_buffer_write", m_wr1 & m_wr2, 1'b0);
      chk("write_expected", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("wr_buffer_is_b2", m_wr2, e.to_b2);
        chk("wr_addr", m_wr2 ? m_a2 : m_a1, e.addr);
        chk("wr_data", m_wr2 ? m_d2 : m_d1, e.data);
        chk("wr_cycle", cyc, e.due);
        chk("front_buffer_quiet", m_wr2 ? {m_a1, m_d1} : {m_a2, m_d2}, 0);
      end
    end else if (exp_q.size() > 0) begin
      chk("write_not_overdue", exp_q[0].due > cyc, 1'b1);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // call at a negedge; returns at the negedge after the accepting edge
  task automatic send_px(input int x, input int y, input int c, input bit last);
    int n = 0;
    px_valid = 1'b1;
    px_x = 9'(x);
    px_y = 8'(y);
    px_color = 3'(c);
    px_last = last;
    while (m_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("px_accept_in_time", n < 200, 1'b1);
    if (n < 200 && x < 320 && y < 240) push_wr(model_b2, y * 320 + x, c, cyc + 1);
    @(negedge clk);
    px_valid = 1'b0;
    px_last = 1'b0;
  endtask

  task automatic send_random(input int count);
    for (int i = 0; i < count; i++)
      send_px($urandom_range(0, 335), $urandom_range(0, 250), $urandom_range(0, 7), 1'b0);
  endtask

  task automatic wait_dd(input logic v, input int max, output int n);
    n = 0;
    while (m_dd !== v && n < max) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic ack_swap();
    int n;
    frame_switched = 1'b1;
    wait_dd(1'b0, 10, n);
    chk("dd_fall_latency", n, 3);
    model_b2 = !model_b2;
  endtask

  task automatic chk_reset_outputs(input string name);
    chk(name, {m_ready, m_dd, m_wr1, m_wr2, m_d1, m_d2, m_a1, m_a2}, 0);
  endtask

  initial begin
    int n;
    int r;
    px_valid = 1'b0; px_last = 1'b0; px_x = '0; px_y = '0; px_color = '0;
    frame_switched = 1'b0;
    rst_a = 1'b0; rst_b = 1'b0;
    sel_b = 1'b1;
    model_b2 = 1'b1;
    tick(3);
    chk_reset_outputs("b_reset_values");
    chk("a_held_in_reset", {a_ready, a_dd, a_wr1, a_wr2, a_d1, a_d2, a_a1, a_a2}, 0);
    #2 rst_b = 1'b1;
    @(negedge clk);

    // frame 1 without clear: BUFFER2
    send_px(5, 2, 5, 1'b0);
    send_random(100);
    send_px(320, 10, 3, 1'b0);
    send_px(0, 240, 6, 1'b1);
    chk("ready_low_in_arm", m_ready, 1'b0);
    wait_dd(1'b1, 10, n);
    chk("dd_rise_latency", n, 1);
    px_valid = 1'b1; px_x = 9'd100; px_y = 8'd100; px_color = 3'd2;
    tick(5);
    chk("dd_held_until_ack", m_dd, 1'b1);
    chk("ready_low_in_done", m_ready, 1'b0);
    ack_swap();

    // frame 2: BUFFER1, abandoned by a reset mid-draw
    send_px(100, 100, 2, 1'b0);
    send_random(60);
    px_valid = 1'b1; px_x = 9'd1; px_y = 8'd1; px_color = 3'd7;
    chk("ready_before_reset", m_ready, 1'b1);
    @(posedge clk);
    #2 rst_b = 1'b0;
    #1 chk_reset_outputs("reset_mid_draw");
    px_valid = 1'b0;
    @(negedge clk);
    #2 rst_b = 1'b1;
    model_b2 = 1'b1;
    @(negedge clk);

    // frame 3: BUFFER2 again, ARM entered with a stale acknowledge
    send_px(9, 9, 4, 1'b0);
    send_random(50);
    send_px(319, 239, 1, 1'b1);
    wait_dd(1'b1, 20, n);
    chk("stale_ack_ignored", m_dd, 1'b0);
    frame_switched = 1'b0;
    wait_dd(1'b1, 10, n);
    chk("dd_rise_after_ack_drop", n, 3);
    ack_swap();
    send_px(3, 4, 1, 1'b0);
    send_px(319, 0, 7, 1'b0);
    tick(3);
    chk("b_scoreboard_drained", exp_q.size(), 0);
    frame_switched = 1'b0;
    #2 rst_b = 1'b0;
    @(negedge clk);
    sel_b = 1'b0;
    model_b2 = 1'b1;
    tick(2);

    // instance with clear enabled, background 3'b010
    chk_reset_outputs("a_reset_values");
    r = cyc;
    for (int k = 0; k < 76800; k++) push_wr(1'b1, k, 2, r + 1 + k);
    #2 rst_a = 1'b1;
    n = 0;
    while (m_ready !== 1'b1 && n < 80000) begin
      @(negedge clk);
      n++;
    end
    chk("clear_cycles_until_ready", n, 76800);
    tick(1);
    chk("clear_all_written", exp_q.size(), 0);
    send_px(5, 2, 5, 1'b0);
    send_px(320, 10, 1, 1'b0);
    send_px(0, 240, 4, 1'b1);
    chk("a_ready_low_in_arm", m_ready, 1'b0);
    wait_dd(1'b1, 10, n);
    chk("a_dd_rise_latency", n, 1);
    ack_swap();
    r = cyc;
    for (int k = 0; k < 40; k++) push_wr(model_b2, k, 2, r + 1 + k);
    tick(40);
    #2 rst_a = 1'b0;
    #1 chk_reset_outputs("reset_mid_clear");
    chk("b1_clear_start_written", exp_q.size(), 0);
    exp_q.delete();
    model_b2 = 1'b1;
    @(negedge clk);
    r = cyc;
    for (int k = 0; k < 40; k++) push_wr(1'b1, k, 2, r + 1 + k);
    #2 rst_a = 1'b1;
    tick(40);
    #2 rst_a = 1'b0;
    #1 chk("clear_restart_written", exp_q.size(), 0);
    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
